// File: rtl/led_seq_fsm.sv
// led_seq_fsm: timed LED sequencer with run/pause/clear control and four patterns
// (shift-left, shift-right, ping-pong, blink-all) plus a pattern-wrap pulse.
// Optional build macro LED_DIM_EN adds a 16-step PWM dimmer on the LED drive.
module led_seq_fsm #(
  parameter int LED_N     = 4,
  parameter int TIME_STEP = 50_000_000,
  parameter int DIM_DUTY  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       mode,
  output logic [LED_N-1:0] led,
  output logic             wrap
);

  localparam int CW = $clog2(TIME_STEP);
  localparam int PW = $clog2(LED_N);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIME_STEP - 1);
  localparam logic [PW-1:0] POS_LAST = PW'(LED_N - 1);

  // Reject parameter values outside their legal ranges at elaboration time
  if (LED_N < 2 || TIME_STEP < 2 || DIM_DUTY < 0 || DIM_DUTY > 16) begin : g_bad_param
    $error("led_seq_fsm: parameter out of legal range");
  end

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    RUN  = 3'b010,
    HOLD = 3'b100
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [PW-1:0]     pos;
  logic              dir_down;
  logic [1:0]        mode_q;
  logic              step_wrap;

  logic              end_cnt;
  logic [PW-1:0]     pos_nxt;
  logic              dir_down_nxt;
  logic              wrap_step;
  logic [LED_N-1:0]  pat;
  logic              dim_gate;

  assign end_cnt   = (cnt == CNT_LAST);
  assign wrap_step = (pos_nxt == '0);

  // Next pattern position for the current mode; a step landing on 0 ends a period
  always_comb begin
    pos_nxt      = pos;
    dir_down_nxt = dir_down;
    case (mode_q)
      2'b00, 2'b01: pos_nxt = (pos == POS_LAST) ? '0 : pos + 1'b1;
      2'b10: begin
        if (!dir_down && pos != POS_LAST) begin
          pos_nxt = pos + 1'b1;
        end else begin
          pos_nxt      = pos - 1'b1;
          dir_down_nxt = (pos != PW'(1));
        end
      end
      default: pos_nxt = (pos == '0) ? PW'(1) : '0;
    endcase
  end

  // LED image for the current state/position; dark while idle
  always_comb begin
    pat = '0;
    if (state != IDLE) begin
      case (mode_q)
        2'b00, 2'b10: pat[pos]            = 1'b1;
        2'b01:        pat[POS_LAST - pos] = 1'b1;
        default:      pat                 = (pos == '0) ? '1 : '0;
      endcase
    end
  end

`ifdef LED_DIM_EN
  logic [3:0] pwm_cnt;

  // Free-running PWM phase counter shared by all LEDs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_cnt <= '0;
    else        pwm_cnt <= pwm_cnt + 1'b1;
  end

  assign dim_gate = ({1'b0, pwm_cnt} < 5'(DIM_DUTY));
`else
  assign dim_gate = 1'b1;
`endif

  // Sequencer FSM: step timer, pattern position, direction and latched mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      pos       <= '0;
      dir_down  <= 1'b0;
      mode_q    <= 2'b00;
      step_wrap <= 1'b0;
    end else begin
      step_wrap <= 1'b0;
      case (state)
        IDLE: begin
          cnt      <= '0;
          pos      <= '0;
          dir_down <= 1'b0;
          if (en && !clr) begin
            state  <= RUN;
            mode_q <= mode;
          end
        end
        RUN: begin
          if (clr) begin
            state    <= IDLE;
            cnt      <= '0;
            pos      <= '0;
            dir_down <= 1'b0;
          end else begin
            if (end_cnt) begin
              cnt      <= '0;
              pos      <= pos_nxt;
              dir_down <= dir_down_nxt;
              if (wrap_step) begin
                step_wrap <= 1'b1;
                mode_q    <= mode;
                dir_down  <= 1'b0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
            if (!en) state <= HOLD;
          end
        end
        HOLD: begin
          if (clr) begin
            state    <= IDLE;
            cnt      <= '0;
            pos      <= '0;
            dir_down <= 1'b0;
          end else if (en) begin
            state <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered LED drive and wrap pulse, both one cycle behind the position update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led  <= '0;
      wrap <= 1'b0;
    end else if (clr) begin
      led  <= '0;
      wrap <= 1'b0;
    end else begin
      led  <= pat & {LED_N{dim_gate}};
      wrap <= step_wrap;
    end
  end

endmodule

// File: tb/tb_led_seq_fsm.sv
// tb_led_seq_fsm: directed self-checking bench for led_seq_fsm (LED_N=4, TIME_STEP=4).
module tb_led_seq_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       clr;
  logic [1:0] mode;
  logic [3:0] led;
  logic       wrap;

  int vectors     = 0;
  int miscompares = 0;

  logic [3:0] shlSeq  [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [3:0] pingSeq [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010};

  led_seq_fsm #(.LED_N(4), .TIME_STEP(4), .DIM_DUTY(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .clr  (clr),
    .mode (mode),
    .led  (led),
    .wrap (wrap)
  );

  // 10 ns system clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic c, input logic [1:0] m);
    en   = e;
    clr  = c;
    mode = m;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic goIdle();
    applyStimulus(1'b0, 1'b1, mode);
    nextCycle();
    checkOutput("clr_led", 32'(led), 32'h0);
    applyStimulus(1'b0, 1'b0, mode);
  endtask

  // Main directed sequence
  initial begin
    logic [3:0] expLed;
    logic       expWrap;
    int         highCnt;

    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'b00);
    #12;
    checkOutput("rst_led", 32'(led), 32'h0);
    checkOutput("rst_wrap", 32'(wrap), 32'h0);
    rst_n = 1'b1;
    #2;

    // Idle with en low: dark, no wrap
    for (int k = 1; k <= 20; k++) begin
      nextCycle();
      checkOutput($sformatf("idle_led k=%0d", k), 32'(led), 32'h0);
      checkOutput($sformatf("idle_wrap k=%0d", k), 32'(wrap), 32'h0);
    end

    // Shift-left: one step per 4 cycles, wrap on return to 0001
    applyStimulus(1'b1, 1'b0, 2'b00);
    for (int k = 1; k <= 21; k++) begin
      nextCycle();
      expLed  = (k < 2) ? 4'b0000 : shlSeq[((k - 2) / 4) % 4];
      expWrap = (k == 18);
      checkOutput($sformatf("shl_led k=%0d", k), 32'(led), 32'(expLed));
      checkOutput($sformatf("shl_wrap k=%0d", k), 32'(wrap), 32'(expWrap));
    end
    goIdle();

    // Ping-pong: endpoints not repeated, period 6 steps
    applyStimulus(1'b1, 1'b0, 2'b10);
    for (int k = 1; k <= 29; k++) begin
      nextCycle();
      expLed  = (k < 2) ? 4'b0000 : pingSeq[((k - 2) / 4) % 6];
      expWrap = (k == 26);
      checkOutput($sformatf("ping_led k=%0d", k), 32'(led), 32'(expLed));
      checkOutput($sformatf("ping_wrap k=%0d", k), 32'(wrap), 32'(expWrap));
    end
    goIdle();

    // Pause mid-step: partial step is resumed, not restarted
    applyStimulus(1'b1, 1'b0, 2'b00);
    for (int k = 1; k <= 21; k++) begin
      nextCycle();
      if (k < 2)       expLed = 4'b0000;
      else if (k < 6)  expLed = 4'b0001;
      else if (k < 20) expLed = 4'b0010;
      else             expLed = 4'b0100;
      checkOutput($sformatf("pause_led k=%0d", k), 32'(led), 32'(expLed));
      checkOutput($sformatf("pause_wrap k=%0d", k), 32'(wrap), 32'h0);
      if (k == 7)  en = 1'b0;
      if (k == 17) en = 1'b1;
    end
    goIdle();

    // Shift-right with mode change mid-period, then clr on an end_cnt cycle
    applyStimulus(1'b1, 1'b0, 2'b01);
    for (int k = 1; k <= 29; k++) begin
      nextCycle();
      if (k < 2)       expLed = 4'b0000;
      else if (k < 6)  expLed = 4'b1000;
      else if (k < 10) expLed = 4'b0100;
      else if (k < 14) expLed = 4'b0010;
      else if (k < 18) expLed = 4'b0001;
      else if (k < 22) expLed = 4'b1111;
      else if (k < 26) expLed = 4'b0000;
      else if (k < 29) expLed = 4'b1111;
      else             expLed = 4'b0000;
      expWrap = (k == 18) || (k == 26);
      checkOutput($sformatf("mchg_led k=%0d", k), 32'(led), 32'(expLed));
      checkOutput($sformatf("mchg_wrap k=%0d", k), 32'(wrap), 32'(expWrap));
      if (k == 8)  mode = 2'b11;
      if (k == 28) clr  = 1'b1;
    end
    applyStimulus(1'b0, 1'b0, 2'b11);
    for (int k = 30; k <= 32; k++) begin
      nextCycle();
      checkOutput($sformatf("clr_idle_led k=%0d", k), 32'(led), 32'h0);
    end

    // Asynchronous reset mid-operation
    applyStimulus(1'b1, 1'b0, 2'b00);
    for (int k = 1; k <= 7; k++) nextCycle();
    checkOutput("pre_arst_led", 32'(led), 32'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_led", 32'(led), 32'h0);
    checkOutput("arst_wrap", 32'(wrap), 32'h0);
    nextCycle();
    checkOutput("arst_hold_led", 32'(led), 32'h0);
    #2;
    rst_n = 1'b1;
    nextCycle();
    checkOutput("post_arst_k1", 32'(led), 32'h0);
    nextCycle();
    checkOutput("post_arst_k2", 32'(led), 32'b0001);
    goIdle();

`ifdef LED_DIM_EN
    // Dimmed all-on step held by pause: each LED lit 4 of 16 cycles
    applyStimulus(1'b1, 1'b0, 2'b11);
    nextCycle();
    nextCycle();
    en = 1'b0;
    nextCycle();
    nextCycle();
    highCnt = 0;
    for (int k = 0; k < 16; k++) begin
      nextCycle();
      if (led == 4'b1111) highCnt++;
      else checkOutput($sformatf("dim_off k=%0d", k), 32'(led), 32'h0);
    end
    checkOutput("dim_duty", 32'(highCnt), 32'd4);
    goIdle();
`else
    highCnt = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
